// File: rtl/tok_pkg.sv
// rtl/tok_pkg.sv - shared tokenizer types and character constants
//
// Purpose: state encoding for the word splitter FSM and the byte values
//          that delimit words in the tokenizer input stream.
// Ports:   none (package)

package tok_pkg;

   typedef enum logic [2:0] {
      FILL  = 3'd0,   // collecting word bytes into the buffer
      TERM  = 3'd1,   // writing the NUL terminator after the word
      START = 3'd2,   // one-cycle matcher start pulse
      WAIT  = 3'd3,   // waiting for the matcher to finish
      EMIT  = 3'd4,   // presenting the per-word result
      DROP  = 3'd5    // discarding the tail of an overlong word
   } splitter_state_t;

   localparam logic [7:0] SEP_CHAR = 8'h20;
   localparam logic [7:0] NUL_CHAR = 8'h00;

endpackage

// File: rtl/word_splitter_if.sv
// rtl/word_splitter_if.sv - byte stream, matcher and result bundle for the splitter
//
// Purpose: groups the splitter's byte input stream, matcher buffer/control
//          signals and per-word result channel.
// Ports (members):
//   in_valid/in_data/in_last/in_ready       byte stream into the splitter
//   rd_addr/rd_data/word_start_addr         matcher read path into the word buffer
//   start/match_done/match_found            matcher control and result
//   out_valid/out_ready/out_found/out_len/out_err  per-word result
// Modports: slave = the splitter, master = its environment.

interface word_splitter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;

   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] word_start_addr;
   logic                  start;
   logic                  match_done;
   logic                  match_found;

   logic                  out_valid;
   logic                  out_ready;
   logic                  out_found;
   logic [ADDR_WIDTH-1:0] out_len;
   logic                  out_err;

   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready,
      input  rd_addr,
      output rd_data, word_start_addr, start,
      input  match_done, match_found,
      output out_valid,
      input  out_ready,
      output out_found, out_len, out_err
   );

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready,
      output rd_addr,
      input  rd_data, word_start_addr, start,
      output match_done, match_found,
      input  out_valid,
      output out_ready,
      input  out_found, out_len, out_err
   );

endinterface

// File: rtl/tok_buffer.sv
// rtl/tok_buffer.sv - word buffer RAM, one sync write port, one async read port
//
// Purpose: holds the current word (null-terminated) for the vocabulary matcher.
// Ports:
//   clk      clock
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address
//   rd_data  mem[rd_addr], combinational
// Contents are intentionally not reset.

module tok_buffer #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/word_splitter.sv
// rtl/word_splitter.sv - splits a byte stream into words and runs each through the matcher
//
// Purpose: buffers each word null-terminated, pulses the matcher start,
//          waits for match_done and presents one result per word.
// Ports:
//   clk   clock, all logic on rising edge
//   rst   synchronous active-high reset
//   bus   word_splitter_if.slave: byte stream in, matcher read/control,
//         result out (found, len, err)

module word_splitter
   import tok_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SEP_CHAR = DATA_WIDTH'(tok_pkg::SEP_CHAR)
) (
   input  logic            clk,
   input  logic            rst,
   word_splitter_if.slave  bus
);

   localparam logic [ADDR_WIDTH-1:0] MAX_LEN = '1;  // DEPTH-1
   localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

   splitter_state_t        state;
   logic [ADDR_WIDTH-1:0]  wlen;

   logic                   accept;
   logic                   is_sep;
   logic                   wr_en;
   logic [DATA_WIDTH-1:0]  wr_data;

   assign accept = bus.in_valid & bus.in_ready;
   assign is_sep = (bus.in_data == SEP_CHAR) || (bus.in_data == DATA_WIDTH'(NUL_CHAR));

   assign bus.word_start_addr = '0;

   // Buffer writes happen only for accepted word bytes that fit, and for
   // the terminator in TERM; everywhere else the matcher sees a stable word.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = bus.in_data;
      if (state == FILL && accept && !is_sep && wlen != MAX_LEN) begin
         wr_en = 1'b1;
      end else if (state == TERM) begin
         wr_en   = 1'b1;
         wr_data = '0;
      end
   end

   tok_buffer #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wlen),
      .wr_data (wr_data),
      .rd_addr (bus.rd_addr),
      .rd_data (bus.rd_data)
   );

   // All outputs are registered from the next-state decision, so in_ready
   // drops on the same edge that leaves FILL/DROP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FILL;
         wlen          <= '0;
         bus.in_ready  <= 1'b0;
         bus.start     <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_found <= 1'b0;
         bus.out_len   <= '0;
         bus.out_err   <= 1'b0;
      end else begin
         bus.start <= 1'b0;
         case (state)
            FILL: begin
               bus.in_ready <= 1'b1;
               if (accept) begin
                  if (is_sep) begin
                     // Leading or repeated separators are simply dropped.
                     if (wlen != '0) begin
                        state        <= TERM;
                        bus.in_ready <= 1'b0;
                     end
                  end else if (wlen != MAX_LEN) begin
                     wlen <= wlen + ONE;
                     if (bus.in_last) begin
                        state        <= TERM;
                        bus.in_ready <= 1'b0;
                     end
                  end else if (bus.in_last) begin
                     // Overflow on the very last byte: nothing left to drop.
                     state         <= EMIT;
                     bus.in_ready  <= 1'b0;
                     bus.out_valid <= 1'b1;
                     bus.out_found <= 1'b0;
                     bus.out_len   <= MAX_LEN;
                     bus.out_err   <= 1'b1;
                  end else begin
                     state <= DROP;
                  end
               end
            end

            TERM: begin
               state     <= START;
               bus.start <= 1'b1;
            end

            START: begin
               state <= WAIT;
            end

            WAIT: begin
               if (bus.match_done) begin
                  state         <= EMIT;
                  bus.out_valid <= 1'b1;
                  bus.out_found <= bus.match_found;
                  bus.out_len   <= wlen;
                  bus.out_err   <= 1'b0;
               end
            end

            DROP: begin
               bus.in_ready <= 1'b1;
               if (accept && (is_sep || bus.in_last)) begin
                  state         <= EMIT;
                  bus.in_ready  <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.out_found <= 1'b0;
                  bus.out_len   <= MAX_LEN;
                  bus.out_err   <= 1'b1;
               end
            end

            EMIT: begin
               if (bus.out_ready) begin
                  state         <= FILL;
                  wlen          <= '0;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
               end
            end

            default: begin
               state        <= FILL;
               wlen         <= '0;
               bus.in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_word_splitter.sv
// tb/tb_word_splitter.sv - self-checking bench for word_splitter

module tb_word_splitter;

   localparam int AW = 4;
   localparam int DW = 8;

   typedef struct packed {
      logic          found;
      logic [AW-1:0] len;
      logic          err;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   word_splitter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   word_splitter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .SEP_CHAR   (8'h20)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   res_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   start_count = 0;
   bit   matcher_en = 1'b1;
   bit   model_found = 1'b0;
   logic md_model = 1'b0, mf_model = 1'b0;
   logic md_inject = 1'b0, mf_inject = 1'b0;

   assign bus.match_done  = md_model | md_inject;
   assign bus.match_found = mf_model | mf_inject;

   function automatic res_t mk(input logic f, input int l, input logic e);
      res_t r;
      r.found = f;
      r.len   = AW'(l);
      r.err   = e;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Matcher model: counts start pulses, answers three cycles later.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (bus.start === 1'b1) begin
            start_count++;
            if (matcher_en) begin
               automatic bit f = model_found;
               repeat (3) @(posedge clk);
               #1;
               md_model = 1'b1;
               mf_model = f;
               @(posedge clk); #1;
               md_model = 1'b0;
               mf_model = 1'b0;
            end
         end
      end
   end

   // Result monitor: pops the scoreboard on every consumed result.
   always @(negedge clk) begin
      res_t e;
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_result observed=%0h expected=none",
                   {bus.out_found, bus.out_len, bus.out_err});
         end else begin
            e = sb.pop_front();
            check("result", 32'({bus.out_found, bus.out_len, bus.out_err}), 32'(e));
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit last);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send_str(input string s, input bit last);
      for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1));
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid !== 1'b0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic check_buf(input string tag, input int addr, input logic [7:0] exp);
      bus.rd_addr = AW'(addr);
      #1;
      check(tag, 32'(bus.rd_data), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.rd_addr   = '0;
      bus.out_ready = 1'b1;

      // Reset values
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(bus.in_ready),        32'd0);
      check("rst_start",     32'(bus.start),           32'd0);
      check("rst_out_valid", 32'(bus.out_valid),       32'd0);
      check("rst_out_found", 32'(bus.out_found),       32'd0);
      check("rst_out_err",   32'(bus.out_err),         32'd0);
      check("rst_out_len",   32'(bus.out_len),         32'd0);
      check("word_start",    32'(bus.word_start_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("fill_in_ready", 32'(bus.in_ready), 32'd1);

      // "cat " with found=1; hold result for 5 cycles
      model_found   = 1'b1;
      bus.out_ready = 1'b0;
      s0 = start_count;
      sb.push_back(mk(1'b1, 3, 1'b0));
      send_str("cat ", 1'b0);
      wait_valid();
      check("cat_starts", 32'(start_count - s0), 32'd1);
      check_buf("cat_buf0", 0, "c");
      check_buf("cat_buf1", 1, "a");
      check_buf("cat_buf2", 2, "t");
      check_buf("cat_buf3", 3, 8'h00);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid",  32'(bus.out_valid), 32'd1);
         check("hold_fields", 32'({bus.out_found, bus.out_len, bus.out_err}),
               32'(mk(1'b1, 3, 1'b0)));
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check("hold_starts", 32'(start_count - s0), 32'd1);
      end
      bus.out_ready = 1'b1;
      drain();

      // "  ab  cd" with in_last on 'd', found=0
      model_found = 1'b0;
      s0 = start_count;
      sb.push_back(mk(1'b0, 2, 1'b0));
      sb.push_back(mk(1'b0, 2, 1'b0));
      send_str("  ab  cd", 1'b1);
      drain();
      check("two_word_starts", 32'(start_count - s0), 32'd2);

      // 20 bytes then space: overflow, no matcher start
      s0 = start_count;
      sb.push_back(mk(1'b0, 15, 1'b1));
      for (int i = 0; i < 20; i++) send(8'("a" + i), 1'b0);
      send(8'h20, 1'b0);
      drain();
      check("ovf_starts", 32'(start_count - s0), 32'd0);
      for (int i = 0; i < 15; i++) check_buf("ovf_buf", i, 8'("a" + i));

      // Next word after overflow processes normally
      model_found = 1'b1;
      sb.push_back(mk(1'b1, 2, 1'b0));
      send_str("hi ", 1'b0);
      drain();
      check("after_ovf_starts", 32'(start_count - s0), 32'd1);
      check_buf("hi_term", 2, 8'h00);

      // Overflow where the 16th byte carries in_last
      s0 = start_count;
      sb.push_back(mk(1'b0, 15, 1'b1));
      for (int i = 0; i < 16; i++) send(8'("A" + i), i == 15);
      drain();
      check("ovf_last_starts", 32'(start_count - s0), 32'd0);

      // Exactly 15 characters closed by in_last: legal, terminator at 15
      s0 = start_count;
      sb.push_back(mk(1'b1, 15, 1'b0));
      for (int i = 0; i < 15; i++) send(8'("A" + i), i == 14);
      drain();
      check("max_word_starts", 32'(start_count - s0), 32'd1);
      check_buf("max_buf14", 14, 8'("A" + 14));
      check_buf("max_term15", 15, 8'h00);

      // Stray match_done in FILL is ignored
      md_inject = 1'b1;
      mf_inject = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      md_inject = 1'b0;
      mf_inject = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("stray_done_valid",    32'(bus.out_valid), 32'd0);
      check("stray_done_in_ready", 32'(bus.in_ready),  32'd1);

      // Reset while waiting on the matcher
      matcher_en = 1'b0;
      s0 = start_count;
      send_str("xy ", 1'b0);
      for (int n = 0; n < 50 && start_count == s0; n++) begin
         @(posedge clk); #1;
      end
      check("wait_start_seen", 32'(start_count - s0), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check("abort_in_ready",  32'(bus.in_ready),  32'd1);
      matcher_en  = 1'b1;
      model_found = 1'b1;
      sb.push_back(mk(1'b1, 2, 1'b0));
      send_str("ok ", 1'b0);
      drain();
      check("abort_fresh_start", 32'(start_count - s0), 32'd2);
      check_buf("ok_buf0", 0, "o");
      check_buf("ok_buf1", 1, "k");
      check_buf("ok_buf2", 2, 8'h00);

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
